// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer (trap_ctrl).
// The software-interrupt source is compiled in only when TRAP_CTRL_SW_IRQ_EN is defined.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2
    } trap_state_e;

    // CSR addresses of the registers this block writes or observes
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Interrupt cause codes (low bits of mcause)
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // mstatus / mie bit positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MSIE_BIT     = 3;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIE_MEIE_BIT     = 11;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of interrupt, commit, CSR-view and trap-control signals around trap_ctrl.
// master = the trap sequencer, slave = the pipeline/CSR-file side.
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            irq_timer;
    logic            irq_ext;
    logic            irq_sw;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            commit_mret;
    logic [XLEN-1:0] csr_mstatus;
    logic [XLEN-1:0] csr_mie;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            flush;
    logic            fetch_stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mepc_we;
    logic            mcause_we;
    logic            mstatus_we;
    logic [XLEN-1:0] mepc_wdata;
    logic [XLEN-1:0] mcause_wdata;
    logic [XLEN-1:0] mstatus_wdata;
    logic            trap_active;

    modport master (
        input  irq_timer, irq_ext, irq_sw, commit_valid, commit_pc, commit_mret,
        input  csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
        output flush, fetch_stall, redirect_valid, redirect_pc,
        output mepc_we, mcause_we, mstatus_we, mepc_wdata, mcause_wdata, mstatus_wdata,
        output trap_active
    );

    modport slave (
        output irq_timer, irq_ext, irq_sw, commit_valid, commit_pc, commit_mret,
        output csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
        input  flush, fetch_stall, redirect_valid, redirect_pc,
        input  mepc_we, mcause_we, mstatus_we, mepc_wdata, mcause_wdata, mstatus_wdata,
        input  trap_active
    );
endinterface

// File: rtl/trap_ctrl_prio_enc.sv
// Fixed-priority interrupt encoder: external > software > timer.
module irq_prio_enc
    import trap_pkg::*;
(
    input  logic       i_pend_e,
    input  logic       i_pend_s,
    input  logic       i_pend_t,
    input  logic       i_mie,
    output logic       o_take,
    output logic [3:0] o_code
);

    // Gate by global MIE and select the highest-priority pending cause
    always_comb begin
        o_take = i_mie & (i_pend_e | i_pend_s | i_pend_t);
        if (i_pend_e) begin
            o_code = CAUSE_MEI;
        end else if (i_pend_s) begin
            o_code = CAUSE_MSI;
        end else begin
            o_code = CAUSE_MTI;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts interrupts at the committing instruction,
// retires MRET, and emits one-cycle CSR write strobes plus flush/redirect.
// Optional: define TRAP_CTRL_SW_IRQ_EN to let irq_sw (cause 3) participate.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int VEC_STRIDE = 4
) (
    input  logic        clk,
    input  logic        reset,
    trap_ctrl_if.master bus
);

    trap_state_e     r_state;
    trap_state_e     w_next_state;
    logic [XLEN-1:0] r_epc;
    logic [3:0]      r_code;

    logic            w_pend_e;
    logic            w_pend_s;
    logic            w_pend_t;
    logic            w_take;
    logic [3:0]      w_code;
    logic            w_accept;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_vec_pc;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_mret_mstatus;
    logic [XLEN-1:0] w_save_mstatus;
    logic            w_unused;

    logic            w_flush;
    logic            w_fetch_stall;
    logic            w_redirect_valid;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_mepc_we;
    logic            w_mcause_we;
    logic            w_mstatus_we;
    logic [XLEN-1:0] w_mepc_wdata;
    logic [XLEN-1:0] w_mcause_wdata;
    logic [XLEN-1:0] w_mstatus_wdata;
    logic            w_trap_active;

    assign w_pend_e = bus.irq_ext   & bus.csr_mie[MIE_MEIE_BIT];
    assign w_pend_t = bus.irq_timer & bus.csr_mie[MIE_MTIE_BIT];
`ifdef TRAP_CTRL_SW_IRQ_EN
    assign w_pend_s = bus.irq_sw    & bus.csr_mie[MIE_MSIE_BIT];
    assign w_unused = ^bus.csr_mie;
`else
    assign w_pend_s = 1'b0;
    assign w_unused = ^{bus.csr_mie, bus.irq_sw};
`endif

    irq_prio_enc u_prio (
        .i_pend_e (w_pend_e),
        .i_pend_s (w_pend_s),
        .i_pend_t (w_pend_t),
        .i_mie    (bus.csr_mstatus[MSTATUS_MIE_BIT]),
        .o_take   (w_take),
        .o_code   (w_code)
    );

    // Derived CSR values: handler target, cause word, and mstatus images for entry and MRET
    always_comb begin
        w_base  = {bus.csr_mtvec[XLEN-1:2], 2'b00};
        if (bus.csr_mtvec[1:0] == MTVEC_MODE_VECTORED) begin
            w_vec_pc = w_base + (XLEN'(VEC_STRIDE) * XLEN'(r_code));
        end else begin
            w_vec_pc = w_base;
        end
        w_cause = {1'b1, {(XLEN-5){1'b0}}, r_code};
        w_mret_mstatus                   = bus.csr_mstatus;
        w_mret_mstatus[MSTATUS_MIE_BIT]  = bus.csr_mstatus[MSTATUS_MPIE_BIT];
        w_mret_mstatus[MSTATUS_MPIE_BIT] = 1'b1;
        w_save_mstatus                   = bus.csr_mstatus;
        w_save_mstatus[MSTATUS_MPIE_BIT] = bus.csr_mstatus[MSTATUS_MIE_BIT];
        w_save_mstatus[MSTATUS_MIE_BIT]  = 1'b0;
    end

    // State register plus capture of trap PC and cause at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_epc   <= '0;
            r_code  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_epc  <= bus.commit_pc;
                r_code <= w_code;
            end else begin
                r_epc  <= r_epc;
                r_code <= r_code;
            end
        end
    end

    // Next-state and output decode; interrupt wins over a simultaneous MRET
    always_comb begin
        w_next_state     = r_state;
        w_accept         = 1'b0;
        w_flush          = 1'b0;
        w_fetch_stall    = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        w_mepc_we        = 1'b0;
        w_mcause_we      = 1'b0;
        w_mstatus_we     = 1'b0;
        w_mepc_wdata     = '0;
        w_mcause_wdata   = '0;
        w_mstatus_wdata  = '0;
        w_trap_active    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take && bus.commit_valid) begin
                    w_accept      = 1'b1;
                    w_flush       = 1'b1;
                    w_fetch_stall = 1'b1;
                    w_trap_active = 1'b1;
                    w_next_state  = SAVE;
                end else if (!w_take && bus.commit_valid && bus.commit_mret) begin
                    w_flush          = 1'b1;
                    w_redirect_valid = 1'b1;
                    w_redirect_pc    = bus.csr_mepc;
                    w_mstatus_we     = 1'b1;
                    w_mstatus_wdata  = w_mret_mstatus;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SAVE: begin
                w_mepc_we       = 1'b1;
                w_mcause_we     = 1'b1;
                w_mstatus_we    = 1'b1;
                w_fetch_stall   = 1'b1;
                w_flush         = 1'b1;
                w_trap_active   = 1'b1;
                w_mepc_wdata    = {r_epc[XLEN-1:2], 2'b00};
                w_mcause_wdata  = w_cause;
                w_mstatus_wdata = w_save_mstatus;
                w_next_state    = VECTOR;
            end
            VECTOR: begin
                w_redirect_valid = 1'b1;
                w_redirect_pc    = w_vec_pc;
                w_trap_active    = 1'b1;
                w_next_state     = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are held at zero while reset is asserted so no partial CSR write escapes
    assign bus.flush          = w_flush          & ~reset;
    assign bus.fetch_stall    = w_fetch_stall    & ~reset;
    assign bus.redirect_valid = w_redirect_valid & ~reset;
    assign bus.redirect_pc    = reset ? '0 : w_redirect_pc;
    assign bus.mepc_we        = w_mepc_we        & ~reset;
    assign bus.mcause_we      = w_mcause_we      & ~reset;
    assign bus.mstatus_we     = w_mstatus_we     & ~reset;
    assign bus.mepc_wdata     = reset ? '0 : w_mepc_wdata;
    assign bus.mcause_wdata   = reset ? '0 : w_mcause_wdata;
    assign bus.mstatus_wdata  = reset ? '0 : w_mstatus_wdata;
    assign bus.trap_active    = w_trap_active    & ~reset;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_trap_ctrl;

`ifdef TRAP_CTRL_SW_IRQ_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    trap_ctrl_if #(.XLEN(32)) bus ();

    trap_ctrl #(.XLEN(32), .VEC_STRIDE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pending trap work: each accepted interrupt schedules a save cycle then a vector cycle
    typedef struct {
        bit          is_save;
        logic [3:0]  code;
        logic [31:0] epc;
    } item_t;
    item_t sched[$];

    logic [134:0] exp_v;
    logic [134:0] obs_v;

    function automatic void model_pick(output bit take, output logic [3:0] code);
        bit pe, ps, pt;
        pe = bus.irq_ext & bus.csr_mie[11];
        ps = SW_EN & bus.irq_sw & bus.csr_mie[3];
        pt = bus.irq_timer & bus.csr_mie[7];
        take = bus.csr_mstatus[3] & (pe | ps | pt);
        code = pe ? 4'd11 : (ps ? 4'd3 : 4'd7);
    endfunction

    function automatic logic [31:0] vec_target(logic [3:0] code);
        logic [31:0] base;
        base = bus.csr_mtvec & ~32'h3;
        if (bus.csr_mtvec[1:0] == 2'b01) return base + 32'(4 * int'(code));
        return base;
    endfunction

    function automatic logic [134:0] model_expect();
        logic f, s, rv, mw, cw, sw, ta;
        logic [31:0] rpc, mwd, cwd, swd;
        bit take;
        logic [3:0] code;
        {f, s, rv, mw, cw, sw, ta} = 7'd0;
        {rpc, mwd, cwd, swd} = 128'd0;
        model_pick(take, code);
        if (reset) begin
            ta = 1'b0;
        end else if (sched.size() > 0) begin
            ta = 1'b1;
            if (sched[0].is_save) begin
                f = 1'b1; s = 1'b1; mw = 1'b1; cw = 1'b1; sw = 1'b1;
                mwd = sched[0].epc & ~32'h3;
                cwd = 32'h8000_0000 | 32'(sched[0].code);
                swd = bus.csr_mstatus;
                swd[7] = bus.csr_mstatus[3];
                swd[3] = 1'b0;
            end else begin
                rv = 1'b1;
                rpc = vec_target(sched[0].code);
            end
        end else if (take && bus.commit_valid) begin
            f = 1'b1; s = 1'b1; ta = 1'b1;
        end else if (bus.commit_valid && bus.commit_mret) begin
            f = 1'b1; rv = 1'b1; sw = 1'b1;
            rpc = bus.csr_mepc;
            swd = bus.csr_mstatus;
            swd[3] = bus.csr_mstatus[7];
            swd[7] = 1'b1;
        end
        return {f, s, rv, rpc, mw, cw, sw, mwd, cwd, swd, ta};
    endfunction

    function automatic logic [134:0] pack_obs();
        return {bus.flush, bus.fetch_stall, bus.redirect_valid, bus.redirect_pc,
                bus.mepc_we, bus.mcause_we, bus.mstatus_we,
                bus.mepc_wdata, bus.mcause_wdata, bus.mstatus_wdata, bus.trap_active};
    endfunction

    task automatic model_advance();
        bit take;
        logic [3:0] code;
        item_t it;
        model_pick(take, code);
        if (reset) begin
            sched.delete();
        end else if (sched.size() > 0) begin
            void'(sched.pop_front());
        end else if (take && bus.commit_valid) begin
            it.is_save = 1'b1; it.code = code; it.epc = bus.commit_pc;
            sched.push_back(it);
            it.is_save = 1'b0;
            sched.push_back(it);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_idle();
        bus.irq_timer = 1'b0; bus.irq_ext = 1'b0; bus.irq_sw = 1'b0;
        bus.commit_valid = 1'b0; bus.commit_pc = 32'd0; bus.commit_mret = 1'b0;
        bus.csr_mstatus = 32'd0; bus.csr_mie = 32'd0;
        bus.csr_mtvec = 32'd0; bus.csr_mepc = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.irq_ext = 1'b1; bus.csr_mie = 32'h888; bus.csr_mstatus = 32'h88;
            bus.commit_valid = 1'b1; bus.commit_mret = 1'(c); bus.commit_pc = $urandom;
            @(negedge clk);
            obs_v = pack_obs(); checks++;
            if (obs_v !== 135'd0) begin
                errors++; $display("FAIL reset c%0d: got %h exp 0", c, obs_v);
            end
            tick();
        end
        reset = 1'b0;
        set_idle();
        @(negedge clk);
        exp_v = model_expect(); obs_v = pack_obs(); checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL reset_idle: got %h exp %h", obs_v, exp_v);
        end
        tick();
    endtask

    task automatic test_vectored_ext();
        set_idle();
        bus.csr_mstatus = 32'h8; bus.csr_mie = 32'h800; bus.csr_mtvec = 32'h1001;
        bus.irq_ext = 1'b1; bus.commit_valid = 1'b1; bus.commit_pc = 32'h40;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_v = model_expect(); obs_v = pack_obs(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL vec_ext c%0d: got %h exp %h", c, obs_v, exp_v);
            end
            checks++;
            if (c == 0 && bus.flush !== 1'b1) begin
                errors++; $display("FAIL vec_ext_flush: got %b exp 1", bus.flush);
            end else if (c == 1 && {bus.mepc_wdata, bus.mcause_wdata, bus.mstatus_wdata}
                         !== {32'h40, 32'h8000_000B, 32'h80}) begin
                errors++; $display("FAIL vec_ext_save: got %h %h %h exp 40 8000000b 80",
                                   bus.mepc_wdata, bus.mcause_wdata, bus.mstatus_wdata);
            end else if (c == 2 && bus.redirect_pc !== 32'h102C) begin
                errors++; $display("FAIL vec_ext_pc: got %h exp 102c", bus.redirect_pc);
            end
            tick();
            bus.irq_ext = 1'b0; bus.commit_valid = 1'b0;
        end
    endtask

    task automatic test_direct_prio();
        set_idle();
        bus.csr_mstatus = 32'h8; bus.csr_mie = 32'h880; bus.csr_mtvec = 32'h1000;
        bus.irq_ext = 1'b1; bus.irq_timer = 1'b1; bus.commit_valid = 1'b1; bus.commit_pc = 32'h60;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_v = model_expect(); obs_v = pack_obs(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL prio c%0d: got %h exp %h", c, obs_v, exp_v);
            end
            checks++;
            if (c == 1 && bus.mcause_wdata !== 32'h8000_000B) begin
                errors++; $display("FAIL prio_cause: got %h exp 8000000b", bus.mcause_wdata);
            end else if (c == 2 && bus.redirect_pc !== 32'h1000) begin
                errors++; $display("FAIL prio_pc: got %h exp 1000", bus.redirect_pc);
            end
            tick();
            bus.commit_valid = 1'b0;
        end
        set_idle();
    endtask

    task automatic test_wait_commit();
        set_idle();
        bus.csr_mstatus = 32'h8; bus.csr_mie = 32'h80; bus.csr_mtvec = 32'h2000;
        bus.irq_timer = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.commit_valid = (c >= 5) ? 1'b1 : 1'b0;
            bus.commit_pc = 32'h100 + 32'(4 * c);
            @(negedge clk);
            exp_v = model_expect(); obs_v = pack_obs(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL wait c%0d: got %h exp %h", c, obs_v, exp_v);
            end
            checks++;
            if (c < 5 && obs_v !== 135'd0) begin
                errors++; $display("FAIL wait_quiet c%0d: got %h exp 0", c, obs_v);
            end else if (c == 6 && bus.mepc_wdata !== 32'h114) begin
                errors++; $display("FAIL wait_epc: got %h exp 114", bus.mepc_wdata);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_mret();
        set_idle();
        bus.csr_mstatus = 32'h80; bus.csr_mepc = 32'h44;
        bus.commit_valid = 1'b1; bus.commit_mret = 1'b1; bus.commit_pc = 32'h200;
        @(negedge clk);
        exp_v = model_expect(); obs_v = pack_obs(); checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL mret: got %h exp %h", obs_v, exp_v);
        end
        checks++;
        if ({bus.flush, bus.redirect_valid, bus.redirect_pc, bus.mstatus_we, bus.mstatus_wdata}
            !== {1'b1, 1'b1, 32'h44, 1'b1, 32'h88}) begin
            errors++; $display("FAIL mret_lit: got pc %h ws %h exp 44 88",
                               bus.redirect_pc, bus.mstatus_wdata);
        end
        tick();
        set_idle();
    endtask

    task automatic test_mret_vs_irq();
        set_idle();
        bus.csr_mstatus = 32'h88; bus.csr_mie = 32'h800; bus.csr_mepc = 32'h44;
        bus.csr_mtvec = 32'h3000; bus.irq_ext = 1'b1;
        bus.commit_valid = 1'b1; bus.commit_mret = 1'b1; bus.commit_pc = 32'h52;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_v = model_expect(); obs_v = pack_obs(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL mret_irq c%0d: got %h exp %h", c, obs_v, exp_v);
            end
            checks++;
            if (c == 0 && bus.redirect_valid !== 1'b0) begin
                errors++; $display("FAIL mret_irq_noredir: got %b exp 0", bus.redirect_valid);
            end else if (c == 1 && bus.mepc_wdata !== 32'h50) begin
                errors++; $display("FAIL mret_irq_epc: got %h exp 50", bus.mepc_wdata);
            end
            tick();
            bus.commit_mret = 1'b0; bus.commit_valid = 1'b0;
        end
        set_idle();
    endtask

    task automatic test_reset_in_save();
        set_idle();
        bus.csr_mstatus = 32'h8; bus.csr_mie = 32'h800; bus.irq_ext = 1'b1;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h70;
        tick();
        reset = 1'b1; bus.commit_valid = 1'b0;
        @(negedge clk);
        obs_v = pack_obs(); checks++;
        if (obs_v !== 135'd0) begin
            errors++; $display("FAIL rst_save: got %h exp 0", obs_v);
        end
        tick();
        reset = 1'b0; bus.irq_ext = 1'b0;
        @(negedge clk);
        obs_v = pack_obs(); checks++;
        if (obs_v !== 135'd0) begin
            errors++; $display("FAIL rst_after: got %h exp 0", obs_v);
        end
        tick();
        bus.csr_mepc = 32'h90; bus.csr_mstatus = 32'h80;
        bus.commit_valid = 1'b1; bus.commit_mret = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h90}) begin
            errors++; $display("FAIL rst_idle_mret: got %b %h exp 1 90",
                               bus.redirect_valid, bus.redirect_pc);
        end
        tick();
        set_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.irq_ext = ($urandom_range(0, 3) == 0);
            bus.irq_sw = ($urandom_range(0, 3) == 0);
            bus.irq_timer = ($urandom_range(0, 3) == 0);
            bus.csr_mie = $urandom;
            bus.csr_mstatus = $urandom;
            bus.csr_mtvec = $urandom;
            bus.csr_mepc = $urandom;
            bus.commit_valid = $urandom_range(0, 1);
            bus.commit_mret = ($urandom_range(0, 3) == 0);
            bus.commit_pc = $urandom;
            @(negedge clk);
            exp_v = model_expect(); obs_v = pack_obs(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL random c%0d: got %h exp %h", c, obs_v, exp_v);
            end
            tick();
        end
        reset = 1'b0;
        set_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_v = model_expect(); obs_v = pack_obs(); checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL drain c%0d: got %h exp %h", c, obs_v, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        set_idle();
        #1;
        test_reset();
        test_vectored_ext();
        test_direct_prio();
        test_wait_commit();
        test_mret();
        test_mret_vs_irq();
        test_reset_in_save();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
